// File: rtl/tff_count_sequencer.sv
// Bounded up/down counter built on a bank of T flip-flops.
// The controller computes a toggle vector each cycle; the bank applies
// Q <= Q ^ T at every non-reset edge, so Q only ever moves through T.
module tff_count_sequencer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             PAUSE,
  input  logic             ABORT,
  input  logic             UP,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_Prime,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       STATE
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HOLD   = 2'b10,
    FINISH = 2'b11
  } state_t;

  state_t           state_q;
  state_t           state_n;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] lim_q;
  logic             up_q;
  logic [WIDTH-1:0] t_c;
  logic             latch_c;
  logic [WIDTH-1:0] inc_vec;
  logic [WIDTH-1:0] dec_vec;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] new_start;
  logic [WIDTH-1:0] old_start;

  // Ripple toggle vectors: a bit toggles when every lower bit is 1 (up) or 0 (down)
  always_comb begin
    inc_vec    = '0;
    dec_vec    = '0;
    inc_vec[0] = 1'b1;
    dec_vec[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      inc_vec[i] = inc_vec[i-1] & q_q[i-1];
      dec_vec[i] = dec_vec[i-1] & ~q_q[i-1];
    end
  end

  assign target    = up_q ? lim_q : '0;
  assign new_start = UP   ? '0    : LIMIT;
  assign old_start = up_q ? '0    : lim_q;

  // Next-state and toggle selection; ABORT beats PAUSE beats counting
  always_comb begin
    state_n = state_q;
    t_c     = '0;
    latch_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          latch_c = 1'b1;
          t_c     = q_q ^ new_start;
          state_n = RUN;
        end
      end
      RUN: begin
        if (ABORT) begin
          state_n = IDLE;
        end else if (PAUSE) begin
          state_n = HOLD;
        end else if (q_q == target) begin
          state_n = FINISH;
        end else begin
          t_c = up_q ? inc_vec : dec_vec;
        end
      end
      HOLD: begin
        if (ABORT) begin
          state_n = IDLE;
        end else if (!PAUSE) begin
          state_n = RUN;
        end
      end
      FINISH: begin
        if (!AUTO_RELOAD || ABORT) begin
          state_n = IDLE;
        end else begin
          t_c     = q_q ^ old_start;
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!RST_N) begin
      t_c     = '0;
      latch_c = 1'b0;
    end
  end

  // Bank update, state register and latched sequence parameters
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_q     <= '0;
      state_q <= IDLE;
      lim_q   <= '0;
      up_q    <= 1'b0;
    end else begin
      q_q     <= q_q ^ t_c;
      state_q <= state_n;
      if (latch_c) begin
        lim_q <= LIMIT;
        up_q  <= UP;
      end
    end
  end

  assign T       = t_c;
  assign Q       = q_q;
  assign Q_Prime = ~q_q;
  assign BUSY    = (state_q != IDLE);
  assign DONE    = (state_q == FINISH);
  assign STATE   = state_q;

endmodule
